// File: rtl/neighbor_list_walker_pkg.sv
// Shared types and widths for the neighbour-list walker.
// Holds the record layout coming from the neighbour-info controller and the
// record layout handed to the edge-PE dispatch stage, plus the width constants
// every file in this slice is built from.
package neighbor_list_walker_pkg;

   localparam int INFO_W      = 16;               // PTR_W + CNT_W
   localparam int PTR_W       = 10;               // Neighbor-ID SRAM address width
   localparam int CNT_W       = 6;                // up to 63 neighbours per node
   localparam int ID_W        = 8;                // neighbour node-ID width
   localparam int Num_Edge_PE = 4;
   localparam int TAG_W       = $clog2(Num_Edge_PE);

   // Controller output record.
   typedef struct packed {
      logic              valid;
      logic [INFO_W-1:0] addr;
      logic [TAG_W-1:0]  PE_tag;
   } neighbor_info_rec_t;

   // Dispatch-side output record.
   typedef struct packed {
      logic             valid;
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] PE_tag;
      logic             last;
   } neighbor_id_out_t;

   // Upper field of the info word is the start pointer.
   function automatic logic [PTR_W-1:0] info_ptr(input logic [INFO_W-1:0] a);
      return a[INFO_W-1:CNT_W];
   endfunction

   // Lower field of the info word is the neighbour count.
   function automatic logic [CNT_W-1:0] info_cnt(input logic [INFO_W-1:0] a);
      return a[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/nlw_sync_fifo.sv
// Small synchronous FIFO with occupancy count, almost-full flag and a sticky
// overflow flag.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   wr_en, wr_data  push (dropped when completely full; sets overflow)
//   rd_en, rd_data  pop (ignored when empty); rd_data is the head, show-ahead
//   count           registered occupancy, 0..DEPTH
//   almost_full     count >= AF_LEVEL
//   overflow        sticky, set by a push into a full FIFO
module nlw_sync_fifo #(
   parameter int DEPTH    = 4,   // power of two, >= 2
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full,
   output logic                   overflow
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   AF_CNT   = (AW+1)'(AF_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_ok, rd_ok;

   // A full FIFO drops the push even if a pop happens in the same cycle.
   assign wr_ok       = wr_en && (count != FULL_CNT);
   assign rd_ok       = rd_en && (count != '0);
   assign rd_data     = mem[rd_ptr];
   assign almost_full = (count >= AF_CNT);

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (wr_en && !wr_ok) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/neighbor_list_walker.sv
// Neighbour-list walker.
// Buffers {addr, PE_tag} records from the neighbour-info controller, decodes
// each into {start pointer, count}, reads the Neighbor-ID SRAM once per
// neighbour and streams the IDs (tagged, with a last marker) over valid/ready.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   in_valid, in_addr, in_PE_tag    record from the controller (no ready)
//   fifo_full                       almost-full back to the controller
//   sram_CEN, sram_WEN, sram_A      SRAM read port (CEN active-low, WEN tied 1)
//   sram_Q                          SRAM data, one cycle after CEN=0
//   out_valid, out_ready            dispatch handshake
//   out_neighbor_id, out_PE_tag     neighbour ID and originating Edge-PE tag
//   out_last                        final ID of the list
//   busy                            FIFO non-empty or walk in progress
//   overflow                        sticky: record arrived with FIFO full
module neighbor_list_walker
   import neighbor_list_walker_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int SKID  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [INFO_W-1:0] in_addr,
   input  logic [TAG_W-1:0]  in_PE_tag,
   output logic              fifo_full,
   output logic              sram_CEN,
   output logic              sram_WEN,
   output logic [PTR_W-1:0]  sram_A,
   input  logic [ID_W-1:0]   sram_Q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   out_neighbor_id,
   output logic [TAG_W-1:0]  out_PE_tag,
   output logic              out_last,
   output logic              busy,
   output logic              overflow
);

   localparam int FW = INFO_W + TAG_W;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] READ    = 2'd1;
   localparam logic [1:0] CAPTURE = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   neighbor_info_rec_t      in_rec;
   neighbor_id_out_t        out_q;
   logic [FW-1:0]           f_data;
   logic [$clog2(DEPTH):0]  f_count;
   logic                    f_empty;
   logic [INFO_W-1:0]       f_addr;
   logic [TAG_W-1:0]        f_tag;

   logic [1:0]              state;
   logic [PTR_W-1:0]        ptr;
   logic [CNT_W-1:0]        rem;
   logic [TAG_W-1:0]        tag;
   logic [PTR_W-1:0]        a_q;
   logic                    pop, advance;

   assign in_rec = '{valid: in_valid, addr: in_addr, PE_tag: in_PE_tag};

   nlw_sync_fifo #(
      .DEPTH    (DEPTH),
      .WIDTH    (FW),
      .AF_LEVEL (DEPTH - SKID)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (in_rec.valid),
      .wr_data     ({in_rec.addr, in_rec.PE_tag}),
      .rd_en       (pop),
      .rd_data     (f_data),
      .count       (f_count),
      .almost_full (fifo_full),
      .overflow    (overflow)
   );

   assign f_empty = (f_count == '0);
   assign f_addr  = f_data[FW-1:TAG_W];
   assign f_tag   = f_data[TAG_W-1:0];

   assign pop     = (state == IDLE) && !f_empty;
   // Accepting a non-final ID issues the next read in the same cycle so that
   // the walk sustains one ID every two cycles.
   assign advance = (state == HOLD) && out_ready && !out_q.last;

   assign sram_WEN = 1'b1;
   assign sram_CEN = !((state == READ) || advance);
   always_comb begin
      sram_A = a_q;
      if (state == READ) sram_A = ptr;
      else if (advance)  sram_A = ptr + 1'b1;
   end

   assign out_valid       = out_q.valid;
   assign out_neighbor_id = out_q.id;
   assign out_PE_tag      = out_q.PE_tag;
   assign out_last        = out_q.last;
   assign busy            = !f_empty || (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
         rem   <= '0;
         tag   <= '0;
         a_q   <= '0;
         out_q <= '0;
      end else begin
         a_q <= sram_A;  // address bus holds its last value between reads
         case (state)
            IDLE: begin
               if (pop) begin
                  ptr <= info_ptr(f_addr);
                  rem <= info_cnt(f_addr);
                  tag <= f_tag;
                  // Zero-count entries are consumed without any SRAM access.
                  if (info_cnt(f_addr) != '0) state <= READ;
               end
            end
            READ: state <= CAPTURE;
            CAPTURE: begin
               out_q <= '{valid: 1'b1, id: sram_Q, PE_tag: tag,
                          last: (rem == CNT_W'(1))};
               state <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_q.valid <= 1'b0;
                  out_q.last  <= 1'b0;
                  if (out_q.last) begin
                     state <= IDLE;
                  end else begin
                     ptr   <= ptr + 1'b1;
                     rem   <= rem - 1'b1;
                     state <= CAPTURE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neighbor_list_walker.sv
// Self-checking bench for neighbor_list_walker: directed lists plus a random
// phase, checked against a list-level model (expected ID stream and expected
// SRAM address stream built from {ptr, count, tag} and the SRAM contents).
module tb_neighbor_list_walker;
   import neighbor_list_walker_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [INFO_W-1:0] in_addr = '0;
   logic [TAG_W-1:0]  in_PE_tag = '0;
   logic              fifo_full, sram_CEN, sram_WEN, out_valid, out_last, busy, overflow;
   logic [PTR_W-1:0]  sram_A;
   logic [ID_W-1:0]   sram_Q = '0;
   logic              out_ready = 1'b0;
   logic [ID_W-1:0]   out_neighbor_id;
   logic [TAG_W-1:0]  out_PE_tag;

   always #5 clk = ~clk;

   neighbor_list_walker #(.DEPTH(4), .SKID(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
      .in_PE_tag(in_PE_tag), .fifo_full(fifo_full), .sram_CEN(sram_CEN),
      .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_Q(sram_Q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_neighbor_id(out_neighbor_id), .out_PE_tag(out_PE_tag),
      .out_last(out_last), .busy(busy), .overflow(overflow));

   // SRAM model: synchronous read.
   logic [ID_W-1:0] mem [1024];
   always @(posedge clk) if (!sram_CEN) sram_Q <= mem[sram_A];

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] tag;
      logic             last;
   } exp_t;

   exp_t             exp_q[$];
   logic [PTR_W-1:0] addr_q[$];
   logic [ID_W-1:0]  id_log[$];
   logic             last_log[$];
   logic [PTR_W-1:0] a_log[$];
   int               hs_cyc[$];
   int               tests = 0, fails = 0, n_last = 0, cyc = 0, ready_mode = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Model: a list of count c at p yields IDs mem[p], mem[p+1], ... with the
   // address wrapping at 2^PTR_W; last only on the final one.
   function automatic void push_list(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] c,
                                     input logic [TAG_W-1:0] t);
      for (int i = 0; i < int'(c); i++) begin
         logic [PTR_W-1:0] a;
         a = p + PTR_W'(i);
         addr_q.push_back(a);
         exp_q.push_back('{id: mem[a], tag: t, last: (i == int'(c) - 1)});
      end
   endfunction

   function automatic void clear_logs();
      id_log.delete(); last_log.delete(); a_log.delete(); hs_cyc.delete();
   endfunction

   // Called #1 after a posedge; returns #1 after the next posedge.
   task automatic send(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] c,
                       input logic [TAG_W-1:0] t, input bit acc = 1'b1);
      in_addr   = {p, c};
      in_PE_tag = t;
      in_valid  = 1'b1;
      if (acc) push_list(p, c, t);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 200);
      if (!out_valid) fail_now(name);
   endtask

   // Returns at a negedge once everything expected has been emitted.
   task automatic wait_drain(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || busy || out_valid) && n < 3000);
      if (exp_q.size() != 0 || busy || out_valid) fail_now(name);
   endtask

   // out_ready driver; mode 3 leaves it to the main sequence.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         2: out_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Compare process: checks reads and outputs against the model each cycle.
   logic            stall = 1'b0;
   logic [ID_W-1:0] h_id;
   logic [TAG_W-1:0] h_tag;
   logic            h_last;
   always @(negedge clk) begin
      if (!reset) begin
         stall = 1'b0;
      end else begin
         if (!sram_CEN) begin
            a_log.push_back(sram_A);
            if (addr_q.size() == 0) fail_now("sram_unexpected_read");
            else chk("sram_A", 32'(sram_A), 32'(addr_q.pop_front()));
         end
         if (out_valid) begin
            if (stall) begin
               chk("hold_id", 32'(out_neighbor_id), 32'(h_id));
               chk("hold_tag", 32'(out_PE_tag), 32'(h_tag));
               chk("hold_last", 32'(out_last), 32'(h_last));
            end
            if (exp_q.size() == 0) begin
               fail_now("unexpected_out_valid");
            end else begin
               chk("out_id", 32'(out_neighbor_id), 32'(exp_q[0].id));
               chk("out_tag", 32'(out_PE_tag), 32'(exp_q[0].tag));
               chk("out_last", 32'(out_last), 32'(exp_q[0].last));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  id_log.push_back(out_neighbor_id);
                  last_log.push_back(out_last);
                  hs_cyc.push_back(cyc);
                  if (out_last) n_last++;
                  stall = 1'b0;
               end else begin
                  stall  = 1'b1;
                  h_id   = out_neighbor_id;
                  h_tag  = out_PE_tag;
                  h_last = out_last;
               end
            end
         end else begin
            if (stall) fail_now("valid_dropped_without_ready");
            stall = 1'b0;
         end
      end
   end

   initial begin
      int n, nl0;
      for (int i = 0; i < 1024; i++) mem[i] = ID_W'($urandom);

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_out_id", 32'(out_neighbor_id), 0);
      chk("rst_out_tag", 32'(out_PE_tag), 0);
      chk("rst_sram_CEN", 32'(sram_CEN), 1);
      chk("rst_sram_WEN", 32'(sram_WEN), 1);
      chk("rst_sram_A", 32'(sram_A), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fifo_full", 32'(fifo_full), 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1;

      // Single list, out_ready high: latency and throughput.
      mem[10'h010] = 8'h21; mem[10'h011] = 8'h22; mem[10'h012] = 8'h23;
      clear_logs();
      send(10'h010, 6'd3, 2'd2);
      // Pop happens in this cycle; count the cycles after it until out_valid.
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 50);
      chk("first_valid_latency", 32'(n - 1), 3);
      wait_drain("single_drain");
      chk("single_cnt", 32'(id_log.size()), 3);
      if (id_log.size() == 3) begin
         chk("single_id0", 32'(id_log[0]), 32'h21);
         chk("single_id1", 32'(id_log[1]), 32'h22);
         chk("single_id2", 32'(id_log[2]), 32'h23);
         chk("single_lastpat", 32'({last_log[0], last_log[1], last_log[2]}), 32'b001);
         chk("throughput_a", 32'(hs_cyc[1] - hs_cyc[0]), 2);
         chk("throughput_b", 32'(hs_cyc[2] - hs_cyc[1]), 2);
      end

      // Backpressure on the second ID.
      clear_logs();
      ready_mode = 0;
      @(posedge clk); #1;
      send(10'h010, 6'd3, 2'd2);
      wait_valid("bp_first_valid");
      ready_mode = 3;
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      wait_valid("bp_second_valid");
      chk("bp_held_id", 32'(out_neighbor_id), 32'h22);
      repeat (5) begin
         @(negedge clk);
         chk("bp_no_read", 32'(sram_CEN), 1);
      end
      ready_mode = 1;
      wait_drain("bp_drain");
      chk("bp_cnt", 32'(id_log.size()), 3);
      chk("bp_reads", 32'(a_log.size()), 3);
      if (id_log.size() == 3) chk("bp_id2", 32'(id_log[2]), 32'h23);

      // Zero-count entry followed by a one-entry list.
      mem[10'h020] = 8'h5A;
      clear_logs();
      @(posedge clk); #1;
      send(10'h100, 6'd0, 2'd1);
      send(10'h020, 6'd1, 2'd3);
      wait_drain("zero_drain");
      chk("zero_cnt", 32'(id_log.size()), 1);
      chk("zero_reads", 32'(a_log.size()), 1);
      if (id_log.size() == 1) begin
         chk("zero_id", 32'(id_log[0]), 32'h5A);
         chk("zero_last", 32'(last_log[0]), 1);
         chk("zero_addr", 32'(a_log[0]), 32'h020);
      end

      // Pointer wrap.
      clear_logs();
      @(posedge clk); #1;
      send(10'h3FE, 6'd3, 2'd0);
      wait_drain("wrap_drain");
      chk("wrap_reads", 32'(a_log.size()), 3);
      if (a_log.size() == 3) begin
         chk("wrap_a0", 32'(a_log[0]), 32'h3FE);
         chk("wrap_a1", 32'(a_log[1]), 32'h3FF);
         chk("wrap_a2", 32'(a_log[2]), 32'h000);
      end

      // Full / overflow: stall the walker on one list, then push 5 records.
      ready_mode = 0;
      @(posedge clk); #1;
      send(10'h040, 6'd1, 2'd1);
      wait_valid("ovf_stall_valid");
      @(posedge clk); #1;
      for (int k = 1; k <= 5; k++) begin
         send(10'(10'h050 + 4 * k), 6'd2, 2'(k), k <= 4);
         @(negedge clk);
         chk("ovf_fifo_full", 32'(fifo_full), 32'(k >= 2));
         chk("ovf_flag", 32'(overflow), 32'(k == 5));
         @(posedge clk); #1;
      end
      @(negedge clk);
      nl0 = n_last;
      ready_mode = 2;
      wait_drain("ovf_drain");
      chk("ovf_lists", 32'(n_last - nl0), 5);
      chk("ovf_sticky", 32'(overflow), 1);

      // Asynchronous reset in the middle of a list.
      ready_mode = 1;
      @(posedge clk); #1;
      send(10'h080, 6'd8, 2'd2);
      send(10'h090, 6'd3, 2'd1);
      wait_valid("rst_mid_valid");
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_last", 32'(out_last), 0);
      chk("mid_rst_out_id", 32'(out_neighbor_id), 0);
      chk("mid_rst_sram_CEN", 32'(sram_CEN), 1);
      chk("mid_rst_sram_A", 32'(sram_A), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_overflow", 32'(overflow), 0);
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); #1 reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_valid", 32'(out_valid), 0);

      // Random lists with random backpressure; the controller paces on fifo_full.
      ready_mode = 2;
      @(posedge clk); #1;
      for (int r = 0; r < 40; r++) begin
         logic [PTR_W-1:0] p;
         logic [CNT_W-1:0] c;
         n = 0;
         while (fifo_full && n < 500) begin @(posedge clk); #1; n++; end
         if (fifo_full) fail_now("rand_full_stuck");
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         p = ($urandom_range(0, 5) == 0) ? PTR_W'(10'h3FC + $urandom_range(0, 3)) : PTR_W'($urandom);
         c = ($urandom_range(0, 4) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
         send(p, c, TAG_W'($urandom));
      end
      wait_drain("rand_drain");
      chk("rand_overflow", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
